// File: rtl/rgen_register_select.sv
// Multi-window register access decoder and sequencer: decodes a host command against
// REGISTERS address windows, holds a one-hot select for WAIT_CYCLES+1 cycles, then responds.
module rgen_register_select #(
  parameter int unsigned                            ADDRESS_WIDTH = 16,
  parameter int unsigned                            REGISTERS     = 4,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]     START_ADDRESS = '0,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]     END_ADDRESS   = '0,
  parameter logic [REGISTERS-1:0]                   READABLE      = '1,
  parameter logic [REGISTERS-1:0]                   WRITABLE      = '1,
  parameter int unsigned                            WAIT_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_command_valid,
  output logic                     o_command_ready,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  output logic [REGISTERS-1:0]     o_select,
  output logic                     o_read,
  output logic                     o_write,
  output logic                     o_response_valid,
  output logic                     o_response_error,
  input  logic                     i_response_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [REGISTERS-1:0]   select_q, select_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;

  logic                   cmd_rd, cmd_wr;
  logic [REGISTERS-1:0]   hit;
  logic [REGISTERS-1:0]   hit_onehot;
  logic                   found;

  // Malformed commands (read == write) enable neither type, so they can never hit.
  assign cmd_rd = i_read & ~i_write;
  assign cmd_wr = i_write & ~i_read;

  // Reserved windows have neither permission bit set and therefore drop out naturally.
  always_comb begin
    hit        = '0;
    hit_onehot = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(REGISTERS); i++) begin
      hit[i] = ((READABLE[i] & cmd_rd) | (WRITABLE[i] & cmd_wr)) &&
               (i_address >= START_ADDRESS[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) &&
               (i_address <= END_ADDRESS[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      if (hit[i] && !found) begin
        hit_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      select_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      read_q   <= read_d;
      write_q  <= write_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    read_d   = read_q;
    write_d  = write_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_command_valid) begin
          if (found) begin
            select_d = hit_onehot;
            read_d   = cmd_rd;
            write_d  = cmd_wr;
            cnt_d    = 4'(WAIT_CYCLES);
            err_d    = 1'b0;
            state_d  = StAccess;
          end else begin
            select_d = '0;
            err_d    = 1'b1;
            state_d  = StRespond;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          select_d = '0;
          read_d   = 1'b0;
          write_d  = 1'b0;
          state_d  = StRespond;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRespond: begin
        if (i_response_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_command_ready  = (state_q == StIdle);
    o_response_valid = (state_q == StRespond);
    o_response_error = err_q;
    o_select         = select_q;
    o_read           = read_q;
    o_write          = write_q;
  end

endmodule
